// File: rtl/fir_stream.sv
// rtl/fir_stream.sv - transposed-form streaming FIR, double-buffered coefficients; FIR_SAT_EN selects output saturation
module fir_stream #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 9,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      coef_wr,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  input  logic                      coef_swap,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam logic [AW:0] TAPS_W = TAPS[AW:0];

  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] shadow_d [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic signed [COEF_W-1:0] active_d [TAPS];
  // z[0] is never stored: its value is the accumulator consumed straight into m_data
  logic signed [ACC_W-1:0]  z_q [1:TAPS-1];
  logic signed [ACC_W-1:0]  z_d [1:TAPS-1];
  logic                     m_valid_q, m_valid_d;
  logic [DATA_W-1:0]        m_data_q, m_data_d;

  logic signed [PW-1:0]     prod_full [TAPS];
  logic signed [ACC_W-1:0]  prod [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic [DATA_W-1:0]        fmt_data;
  logic                     accept;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  // Handshake and per-tap products against the current active bank
  always_comb begin
    s_ready = !flush && (!m_valid_q || m_ready);
    accept  = s_valid && s_ready;
    for (int k = 0; k < TAPS; k++) begin
      prod_full[k] = active_q[k] * $signed(s_data);
      prod[k]      = {{AW{prod_full[k][PW-1]}}, prod_full[k]};
    end
    acc = prod[0] + z_q[1];
  end

  // Round half up by adding half an LSB of the kept result before the arithmetic shift
  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (OUT_SHIFT - 1);
      assign rnd = (acc + HALF) >>> OUT_SHIFT;
    end else begin : g_noround
      assign rnd = acc;
    end
  endgenerate

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the rounded result into the signed output range
  always_comb begin
    fmt_data = rnd[DATA_W-1:0];
    if (rnd > SAT_MAX) begin
      fmt_data = SAT_MAX[DATA_W-1:0];
    end else if (rnd < SAT_MIN) begin
      fmt_data = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  logic unused_rnd_hi;

  assign fmt_data      = rnd[DATA_W-1:0];
  assign unused_rnd_hi = ^rnd[ACC_W-1:DATA_W];
`endif

  // Next-state: coefficient banks, delay line and output register
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    z_d       = z_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    // swap reads shadow_q, so a same-cycle write only reaches the shadow bank
    if (coef_swap) begin
      active_d = shadow_q;
    end
    if (coef_wr && ({1'b0, coef_addr} < TAPS_W)) begin
      shadow_d[coef_addr] = coef_data;
    end

    if (flush) begin
      for (int k = 1; k < TAPS; k++) begin
        z_d[k] = '0;
      end
      m_valid_d = 1'b0;
    end else if (accept) begin
      for (int k = 1; k < TAPS - 1; k++) begin
        z_d[k] = prod[k] + z_q[k+1];
      end
      z_d[TAPS-1] = prod[TAPS-1];
      m_data_d    = fmt_data;
      m_valid_d   = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      for (int k = 1; k < TAPS; k++) begin
        z_q[k] <= '0;
      end
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      z_q       <= z_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// tb/tb_fir_stream.sv - scoreboard testbench for fir_stream
`timescale 1ns/1ps
module tb_fir_stream;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 9;
  localparam int OUT_SHIFT = 15;
  localparam int AW        = $clog2(TAPS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              coef_wr = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              coef_swap = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;

  int checks = 0;
  int failures = 0;

  logic [COEF_W-1:0] imp_coef [TAPS];
  logic [COEF_W-1:0] max_coef [TAPS];
  logic [COEF_W-1:0] k1_coef  [TAPS];
  logic [DATA_W-1:0] imp_resp [10];

  longint shadow_m [TAPS];
  longint active_m [TAPS];
  longint hx [TAPS];
  longint hc [TAPS][TAPS];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  fir_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  function automatic logic [DATA_W-1:0] fmt_model(input longint s);
    longint r;
    r = (s + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[DATA_W-1:0];
  endfunction

  // Direct-form reference: each past sample is weighted by the bank active when it was accepted
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_v;
    longint sum;
    if (!rst_n) begin
      exp_q.delete();
      for (int j = 0; j < TAPS; j++) begin
        shadow_m[j] = 0;
        active_m[j] = 0;
        hx[j] = 0;
        for (int k = 0; k < TAPS; k++) hc[j][k] = 0;
      end
    end else begin
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_output got=%h with nothing expected", m_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (m_data !== exp_v) begin
            failures++;
            $display("FAIL sb_data got=%h exp=%h", m_data, exp_v);
          end
        end
      end
      if (flush) begin
        if (m_valid && !m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        for (int j = 0; j < TAPS; j++) hx[j] = 0;
      end else if (s_valid && s_ready) begin
        for (int j = TAPS - 1; j > 0; j--) begin
          hx[j] = hx[j-1];
          for (int k = 0; k < TAPS; k++) hc[j][k] = hc[j-1][k];
        end
        hx[0] = longint'($signed(s_data));
        for (int k = 0; k < TAPS; k++) hc[0][k] = active_m[k];
        sum = 0;
        for (int j = 0; j < TAPS; j++) sum += hc[j][j] * hx[j];
        exp_q.push_back(fmt_model(sum));
      end
      if (coef_swap) begin
        for (int k = 0; k < TAPS; k++) active_m[k] = shadow_m[k];
      end
      if (coef_wr && int'(coef_addr) < TAPS) shadow_m[coef_addr] = longint'($signed(coef_data));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_swap(input logic [COEF_W-1:0] c [TAPS]);
    for (int k = 0; k < TAPS; k++) begin
      coef_wr = 1'b1; coef_addr = AW'(k); coef_data = c[k];
      tick();
    end
    coef_wr = 1'b0;
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] x);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = x;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout s_ready stayed %b for %0d cycles", s_ready, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 3;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_impulse(input string name);
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 16'h7FFF : 16'h0000);
      checks += 2;
      if (m_valid !== 1'b1) begin failures++; $display("FAIL %s_valid[%0d] got=%b exp=1", name, i, m_valid); end
      if (m_data !== imp_resp[i]) begin
        failures++;
        $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, m_data, imp_resp[i]);
      end
    end
  endtask

  task automatic test_impulse;
    load_and_swap(imp_coef);
    run_impulse("impulse");
    drain("impulse");
  endtask

  task automatic test_dc_step;
    do_flush();
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(16'h4000);
    drain("dc_step");
  endtask

  task automatic test_saturation;
    logic [DATA_W-1:0] want;
`ifdef FIR_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h7FEE;
`endif
    load_and_swap(max_coef);
    do_flush();
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) send(16'h7FFF);
    checks++;
    if (m_data !== want) begin failures++; $display("FAIL saturation_data got=%h exp=%h", m_data, want); end
    drain("saturation");
    load_and_swap(imp_coef);
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] held;
    do_flush();
    m_ready = 1'b1;
    send(16'h7FFF);
    m_ready = 1'b0;
    held = m_data;
    s_valid = 1'b1;
    s_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready[%0d] got=%b exp=0", i, s_ready); end
      if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid[%0d] got=%b exp=1", i, m_valid); end
      if (m_data !== held) begin failures++; $display("FAIL bp_m_data[%0d] got=%h exp=%h", i, m_data, held); end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(16'h1234);
    for (int i = 0; i < 10; i++) send(DATA_W'($urandom_range(0, 65535)));
    drain("backpressure");
  endtask

  task automatic test_swap_edge;
    do_flush();
    m_ready = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      coef_wr = 1'b1; coef_addr = AW'(k); coef_data = k1_coef[k];
      tick();
    end
    coef_wr = 1'b0;
    coef_swap = 1'b1;
    send(16'h7FFF);
    coef_swap = 1'b0;
    checks++;
    if (m_data !== 16'h04F6) begin failures++; $display("FAIL swap_same_cycle got=%h exp=04f6", m_data); end
    for (int i = 0; i < 4; i++) send(16'h0000);
    coef_wr = 1'b1; coef_addr = AW'(TAPS); coef_data = 16'h7FFF;
    tick();
    coef_wr = 1'b1; coef_addr = '0; coef_data = 16'h2000; coef_swap = 1'b1;
    tick();
    coef_wr = 1'b0; coef_swap = 1'b0;
    do_flush();
    send(16'h7FFF);
    checks++;
    if (m_data !== 16'h1000) begin failures++; $display("FAIL swap_prewrite got=%h exp=1000", m_data); end
    for (int i = 0; i < 9; i++) send(16'h0000);
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    do_flush();
    send(16'h7FFF);
    checks++;
    if (m_data !== 16'h2000) begin failures++; $display("FAIL swap_postwrite got=%h exp=2000", m_data); end
    for (int i = 0; i < 9; i++) send(16'h0000);
    drain("swap_edge");
  endtask

  task automatic test_flush;
    load_and_swap(imp_coef);
    m_ready = 1'b1;
    send(16'h5555);
    send(16'hA0A0);
    m_ready = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL flush_s_ready got=%b exp=0", s_ready); end
    tick();
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_m_valid got=%b exp=0", m_valid); end
    run_impulse("flush_impulse");
    drain("flush");
  endtask

  task automatic test_reset_mid;
    m_ready = 1'b0;
    send(16'h7FFF);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_m_valid got=%b exp=0", m_valid); end
    if (m_data !== '0) begin failures++; $display("FAIL rst_mid_m_data got=%h exp=0000", m_data); end
    tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(i[0] ? 16'h8000 : 16'h7FFF);
      checks++;
      if (m_data !== '0) begin failures++; $display("FAIL rst_mid_zero_out[%0d] got=%h exp=0000", i, m_data); end
    end
    drain("reset_mid");
  endtask

  initial begin
    imp_coef = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
                 16'h1496, 16'h1089, 16'h0AE4, 16'h04F6};
    imp_resp = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
                 16'h1496, 16'h1089, 16'h0AE4, 16'h04F6, 16'h0000};
    for (int k = 0; k < TAPS; k++) begin
      max_coef[k] = 16'h7FFF;
      k1_coef[k]  = 16'h1000;
    end
    test_reset();
    test_impulse();
    test_dc_step();
    test_saturation();
    test_backpressure();
    test_swap_edge();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
